// File: rtl/autoconfig_initiator.sv
// autoconfig_initiator: scans one AUTOCONFIG card over a nibble-wide bus,
// collects its ID registers, then assigns a base address or shuts it up.
// Option: define AUTOCONFIG_SERIAL_READ_EN to also read the 32-bit serial.
// Ports: CLK, RESET_n (async, active-low); start pulse;
//   bus_req/bus_read/bus_addr/bus_dout/bus_din/bus_ack access handshake;
//   CFGIN_n/card_cfgout_n config chain; busy/done/found/error status;
//   er_type/prod_id/mfg_id/serial results.
module autoconfig_initiator #(
    parameter logic [3:0] BASE_NIBBLE = 4'h1,
    parameter logic [7:0] TIMEOUT     = 8'd255
) (
    input  logic        CLK,
    input  logic        RESET_n,
    input  logic        start,
    output logic        bus_req,
    output logic        bus_read,
    output logic [6:0]  bus_addr,
    output logic [3:0]  bus_dout,
    input  logic [3:0]  bus_din,
    input  logic        bus_ack,
    output logic        CFGIN_n,
    input  logic        card_cfgout_n,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic        error,
    output logic [7:0]  er_type,
    output logic [7:0]  prod_id,
    output logic [15:0] mfg_id,
    output logic [31:0] serial
);

    typedef enum logic [2:0] {
        S_IDLE, S_ENABLE, S_READ, S_CHECK,
        S_WRITE_BASE, S_SHUTUP, S_WAIT_CHAIN, S_FINISH
    } state_t;

`ifdef AUTOCONFIG_SERIAL_READ_EN
    localparam logic [4:0] LAST_IDX = 5'h13;
`else
    localparam logic [4:0] LAST_IDX = 5'h0B;
`endif

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        read_q, read_d;
    logic [6:0]  addr_q, addr_d;
    logic [3:0]  dout_q, dout_d;
    logic        cfgin_n_q, cfgin_n_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        found_q, found_d;
    logic        error_q, error_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  er_type_q, er_type_d;
    logic [7:0]  prod_id_q, prod_id_d;
    logic [15:0] mfg_id_q, mfg_id_d;
    logic        fin, fail;
    logic [3:0]  nib_inv;
    logic [1:0]  mpos;
`ifdef AUTOCONFIG_SERIAL_READ_EN
    logic [31:0] serial_q, serial_d;
    logic [2:0]  spos;
    // index 0x0C lands in nibble 7, 0x13 in nibble 0
    assign spos = 3'd3 - idx_q[2:0];
`endif

    // everything past the type byte is stored inverted on the card
    assign nib_inv = ~bus_din;
    assign mpos    = 2'd3 - idx_q[1:0];

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        read_d    = read_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        cfgin_n_d = cfgin_n_q;
        busy_d    = busy_q;
        done_d    = done_q;
        found_d   = found_q;
        error_d   = error_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        er_type_d = er_type_q;
        prod_id_d = prod_id_q;
        mfg_id_d  = mfg_id_q;
`ifdef AUTOCONFIG_SERIAL_READ_EN
        serial_d  = serial_q;
`endif
        fin  = 1'b0;
        fail = 1'b0;

        case (state_q)
            S_IDLE, S_FINISH: begin
                if (state_q == S_FINISH) state_d = S_IDLE;
                if (start) begin
                    state_d   = S_ENABLE;
                    cfgin_n_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    found_d   = 1'b0;
                    error_d   = 1'b0;
                end
            end
            S_ENABLE: begin
                idx_d   = 5'h00;
                state_d = S_READ;
            end
            S_READ: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    read_d = 1'b1;
                    addr_d = {2'b00, idx_q};
                    cnt_d  = 8'd0;
                end else if (bus_ack) begin
                    req_d = 1'b0;
                    if (idx_q == 5'h00) er_type_d[7:4] = bus_din;
                    else if (idx_q == 5'h01) er_type_d[3:0] = bus_din;
                    else if (idx_q == 5'h02) prod_id_d[7:4] = nib_inv;
                    else if (idx_q == 5'h03) prod_id_d[3:0] = nib_inv;
                    else if (idx_q >= 5'h08 && idx_q <= 5'h0B)
                        mfg_id_d[{mpos, 2'b00} +: 4] = nib_inv;
`ifdef AUTOCONFIG_SERIAL_READ_EN
                    else if (idx_q >= 5'h0C)
                        serial_d[{spos, 2'b00} +: 4] = nib_inv;
`endif
                    if (idx_q == LAST_IDX) state_d = S_CHECK;
                    else if (idx_q == 5'h05) idx_d = 5'h08;
                    else idx_d = idx_q + 5'd1;
                end else if (cnt_q == TIMEOUT) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_CHECK: begin
                if (er_type_q[7:6] == 2'b10 && mfg_id_q != 16'h0000
                    && mfg_id_q != 16'hFFFF) begin
                    found_d = 1'b1;
                    state_d = S_WRITE_BASE;
                end else begin
                    state_d = S_SHUTUP;
                end
            end
            S_WRITE_BASE, S_SHUTUP: begin
                if (!req_q) begin
                    req_d  = 1'b1;
                    read_d = 1'b0;
                    cnt_d  = 8'd0;
                    if (state_q == S_WRITE_BASE) begin
                        addr_d = 7'h11;
                        dout_d = BASE_NIBBLE;
                    end else begin
                        addr_d = 7'h13;
                        dout_d = 4'h0;
                    end
                end else if (bus_ack) begin
                    req_d   = 1'b0;
                    read_d  = 1'b1;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT_CHAIN;
                end else if (cnt_q == TIMEOUT) begin
                    fail = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_WAIT_CHAIN: begin
                if (!card_cfgout_n) fin = 1'b1;
                else if (cnt_q == TIMEOUT) fail = 1'b1;
                else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (fail) begin
            fin     = 1'b1;
            req_d   = 1'b0;
            read_d  = 1'b1;
            error_d = 1'b1;
            found_d = 1'b0;
        end
        if (fin) begin
            cfgin_n_d = 1'b1;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = S_FINISH;
        end
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            read_q    <= 1'b1;
            addr_q    <= 7'h00;
            dout_q    <= 4'h0;
            cfgin_n_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            found_q   <= 1'b0;
            error_q   <= 1'b0;
            idx_q     <= 5'h00;
            cnt_q     <= 8'd0;
            er_type_q <= 8'h00;
            prod_id_q <= 8'h00;
            mfg_id_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            dout_q    <= dout_d;
            cfgin_n_q <= cfgin_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            found_q   <= found_d;
            error_q   <= error_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            er_type_q <= er_type_d;
            prod_id_q <= prod_id_d;
            mfg_id_q  <= mfg_id_d;
        end
    end

`ifdef AUTOCONFIG_SERIAL_READ_EN
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) serial_q <= 32'h0;
        else serial_q <= serial_d;
    end
    assign serial = serial_q;
`else
    assign serial = 32'h0;
`endif

    assign bus_req  = req_q;
    assign bus_read = read_q;
    assign bus_addr = addr_q;
    assign bus_dout = dout_q;
    assign CFGIN_n  = cfgin_n_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign found    = found_q;
    assign error    = error_q;
    assign er_type  = er_type_q;
    assign prod_id  = prod_id_q;
    assign mfg_id   = mfg_id_q;

endmodule

// File: tb/tb_autoconfig_initiator.sv
// Bench for autoconfig_initiator: a behavioural card answers the bus,
// a register-level model predicts results and the access sequence.
module tb_autoconfig_initiator;
  localparam logic [3:0] BASE = 4'h1;
`ifdef AUTOCONFIG_SERIAL_READ_EN
  localparam int LAST = 19;
  localparam bit SER = 1;
`else
  localparam int LAST = 11;
  localparam bit SER = 0;
`endif
  localparam logic [81:0] RST_VEC = {1'b0, 1'b1, 7'h0, 4'h0, 1'b1, 4'b0,
                                     8'h0, 8'h0, 16'h0, 32'h0};

  logic CLK = 0, RESET_n = 0, start = 0;
  logic bus_ack = 0, card_cfgout_n = 1;
  logic [3:0] bus_din = 0;
  logic bus_req, bus_read, CFGIN_n, busy, done, found, error;
  logic [6:0] bus_addr;
  logic [3:0] bus_dout;
  logic [7:0] er_type, prod_id;
  logic [15:0] mfg_id;
  logic [31:0] serial;

  autoconfig_initiator #(.BASE_NIBBLE(BASE), .TIMEOUT(8'd255)) dut (
    .CLK(CLK), .RESET_n(RESET_n), .start(start),
    .bus_req(bus_req), .bus_read(bus_read), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack),
    .CFGIN_n(CFGIN_n), .card_cfgout_n(card_cfgout_n),
    .busy(busy), .done(done), .found(found), .error(error),
    .er_type(er_type), .prod_id(prod_id), .mfg_id(mfg_id),
    .serial(serial));

  always #5 CLK = ~CLK;

  int tests = 0, fails = 0;
  logic [7:0] c_type, c_prod, c_flags;
  logic [15:0] c_mfg;
  logic [31:0] c_ser;
  bit c_absent = 0, chain_never = 0;
  int ack_delay = 3, chain_delay = 2, hang_idx = -1;
  bit spur_req = 0, spur_seen = 0;
  int hang_cycles = 0, wait_cnt = 0, chain_cnt = 0;
  bit armed = 0;
  logic [7:0] m_type = 0, m_prod = 0;
  logic [15:0] m_mfg = 0;
  logic [31:0] m_ser = 0;
  logic [11:0] log_q[$];
  logic [11:0] exp_q[$];

  function automatic logic [3:0] card_nib(int idx);
    logic [31:0] v;
    if (c_absent) return 4'hF;
    if (idx == 0) return c_type[7:4];
    if (idx == 1) return c_type[3:0];
    if (idx <= 3) v = 32'(c_prod) >> (4 * (3 - idx));
    else if (idx <= 5) v = 32'(c_flags) >> (4 * (5 - idx));
    else if (idx <= 11) v = 32'(c_mfg) >> (4 * (11 - idx));
    else v = c_ser >> (4 * (19 - idx));
    return ~v[3:0];
  endfunction

  // card: acks after ack_delay clocks, raises chain after a write
  initial begin
    forever begin
      @(negedge CLK);
      bus_ack = 0;
      if (CFGIN_n) begin
        armed = 0;
        card_cfgout_n = 1;
      end else if (armed) begin
        if (chain_cnt > 0) chain_cnt--;
        else if (!chain_never) card_cfgout_n = 0;
      end
      if (bus_req === 1'b1) begin
        wait_cnt++;
        if (bus_read && int'(bus_addr) == hang_idx) hang_cycles++;
        else if (wait_cnt >= ack_delay) begin
          bus_din = bus_read ? card_nib(int'(bus_addr)) : 4'h0;
          bus_ack = 1;
          log_q.push_back({bus_read, bus_addr, bus_read ? 4'h0 : bus_dout});
          wait_cnt = 0;
          if (!bus_read) begin
            armed = 1;
            chain_cnt = chain_delay;
          end
        end
      end else begin
        wait_cnt = 0;
        if (spur_req != spur_seen) begin
          spur_seen = spur_req;
          bus_ack = 1;
          bus_din = 4'h5;
        end
      end
    end
  end

  function automatic void model_full();
    m_type = c_absent ? 8'hFF : c_type;
    m_prod = c_absent ? 8'h00 : c_prod;
    m_mfg = c_absent ? 16'h0 : c_mfg;
    m_ser = (c_absent || !SER) ? 32'h0 : c_ser;
  endfunction

  function automatic bit card_valid();
    return m_type[7:6] == 2'b10 && m_mfg != 16'h0 && m_mfg != 16'hFFFF;
  endfunction

  function automatic logic [66:0] res_vec(bit f, bit d, bit e);
    return {m_type, m_prod, m_mfg, m_ser, f, d, e};
  endfunction

  // reads in index order, stopping before stop_idx; then the write
  function automatic void build_exp(int stop_idx, bit wr, bit valid);
    exp_q.delete();
    for (int i = 0; i <= LAST; i++) begin
      if (i == 6 || i == 7) continue;
      if (i == stop_idx) return;
      exp_q.push_back({1'b1, 7'(i), 4'h0});
    end
    if (wr) exp_q.push_back(valid ? {1'b0, 7'h11, BASE} : {1'b0, 7'h13, 4'h0});
  endfunction

  function automatic bit log_ok(int base);
    if (log_q.size() - base != exp_q.size()) return 0;
    foreach (exp_q[i]) if (log_q[base + i] !== exp_q[i]) return 0;
    return 1;
  endfunction

  task automatic new_card();
    c_absent = 0;
    c_type = 8'($urandom);
    if ($urandom_range(0, 2) != 0) c_type[7:6] = 2'b10;
    c_prod = 8'($urandom);
    c_flags = 8'($urandom);
    case ($urandom_range(0, 5))
      0: c_mfg = 16'h0000;
      1: c_mfg = 16'hFFFF;
      default: c_mfg = 16'($urandom);
    endcase
    c_ser = $urandom;
  endtask

  task automatic run_scan(output logic [2:0] st);
    @(negedge CLK);
    start = 1;
    @(negedge CLK);
    start = 0;
    st = {busy, CFGIN_n, done};
    for (int i = 0; i < 3000 && done !== 1'b1; i++) @(negedge CLK);
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if ({bus_req, bus_read, bus_addr, bus_dout, CFGIN_n, busy, done, found,
         error, er_type, prod_id, mfg_id, serial} !== RST_VEC) begin
      fails++;
      $display("FAIL reset outputs got %h exp %h", {bus_req, bus_read,
               bus_addr, bus_dout, CFGIN_n, busy, done, found, error,
               er_type, prod_id, mfg_id, serial}, RST_VEC);
    end
    @(negedge CLK);
    RESET_n = 1;
  endtask

  task automatic test_fixed();
    logic [2:0] st;
    int base = log_q.size();
    c_absent = 0; c_type = 8'hA4; c_prod = 8'h72; c_mfg = 16'h07DB;
    c_ser = 32'd421; c_flags = 8'($urandom);
    ack_delay = 3; chain_delay = 2;
    model_full();
    build_exp(-1, 1, card_valid());
    run_scan(st);
    tests++;
    if (st !== 3'b100) begin
      fails++;
      $display("FAIL fixed start_status got %b exp 100", st);
    end
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error}
        !== res_vec(1, 1, 0)) begin
      fails++;
      $display("FAIL fixed results got %h exp %h", {er_type, prod_id,
               mfg_id, serial, found, done, error}, res_vec(1, 1, 0));
    end
    tests++;
    if (!log_ok(base)) begin
      fails++;
      $display("FAIL fixed accesses got %0d exp %0d entries",
               log_q.size() - base, exp_q.size());
    end
    tests++;
    if ({bus_req, CFGIN_n, busy} !== 3'b010) begin
      fails++;
      $display("FAIL fixed end_bus got %b exp 010", {bus_req, CFGIN_n, busy});
    end
  endtask

  task automatic test_random();
    logic [2:0] st;
    int base;
    bit v;
    for (int k = 0; k < 5; k++) begin
      new_card();
      ack_delay = $urandom_range(1, 4);
      chain_delay = $urandom_range(0, 5);
      model_full();
      v = card_valid();
      build_exp(-1, 1, v);
      base = log_q.size();
      run_scan(st);
      tests++;
      if ({er_type, prod_id, mfg_id, serial, found, done, error}
          !== res_vec(v, 1, 0)) begin
        fails++;
        $display("FAIL random%0d results got %h exp %h", k, {er_type,
                 prod_id, mfg_id, serial, found, done, error}, res_vec(v, 1, 0));
      end
      tests++;
      if (!log_ok(base)) begin
        fails++;
        $display("FAIL random%0d accesses got %0d exp %0d entries", k,
                 log_q.size() - base, exp_q.size());
      end
    end
  endtask

  task automatic test_absent();
    logic [2:0] st;
    int base = log_q.size();
    c_absent = 1; ack_delay = 2; chain_delay = 1;
    model_full();
    build_exp(-1, 1, 0);
    run_scan(st);
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error}
        !== res_vec(0, 1, 0)) begin
      fails++;
      $display("FAIL absent results got %h exp %h", {er_type, prod_id,
               mfg_id, serial, found, done, error}, res_vec(0, 1, 0));
    end
    tests++;
    if (!log_ok(base)) begin
      fails++;
      $display("FAIL absent accesses got %0d exp %0d entries",
               log_q.size() - base, exp_q.size());
    end
    c_absent = 0;
  endtask

  task automatic test_timeout();
    logic [2:0] st;
    int base = log_q.size();
    int h0 = hang_cycles;
    new_card();
    ack_delay = 3; hang_idx = 2;
    m_type = c_type;
    build_exp(2, 0, 0);
    run_scan(st);
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error}
        !== res_vec(0, 1, 1)) begin
      fails++;
      $display("FAIL timeout results got %h exp %h", {er_type, prod_id,
               mfg_id, serial, found, done, error}, res_vec(0, 1, 1));
    end
    tests++;
    if ({bus_req, CFGIN_n, busy} !== 3'b010) begin
      fails++;
      $display("FAIL timeout bus got %b exp 010", {bus_req, CFGIN_n, busy});
    end
    tests++;
    if (hang_cycles - h0 < 255 || hang_cycles - h0 > 257) begin
      fails++;
      $display("FAIL timeout wait got %0d exp 255..257", hang_cycles - h0);
    end
    tests++;
    if (!log_ok(base)) begin
      fails++;
      $display("FAIL timeout accesses got %0d exp %0d entries",
               log_q.size() - base, exp_q.size());
    end
    hang_idx = -1;
  endtask

  task automatic test_chain_timeout();
    logic [2:0] st;
    int base = log_q.size();
    new_card();
    chain_never = 1;
    model_full();
    build_exp(-1, 1, card_valid());
    run_scan(st);
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error}
        !== res_vec(0, 1, 1)) begin
      fails++;
      $display("FAIL chain_to results got %h exp %h", {er_type, prod_id,
               mfg_id, serial, found, done, error}, res_vec(0, 1, 1));
    end
    tests++;
    if (!log_ok(base)) begin
      fails++;
      $display("FAIL chain_to accesses got %0d exp %0d entries",
               log_q.size() - base, exp_q.size());
    end
    chain_never = 0;
  endtask

  task automatic test_mid_reset();
    logic [2:0] st;
    int base;
    bit hit = 0;
    new_card();
    @(negedge CLK);
    start = 1;
    @(negedge CLK);
    start = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(negedge CLK);
      if (bus_req === 1'b1 && bus_addr === 7'h09) hit = 1;
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL midreset reach_idx9 got 0 exp 1");
    end
    #2 RESET_n = 0;
    #1;
    tests++;
    if ({bus_req, bus_read, bus_addr, bus_dout, CFGIN_n, busy, done, found,
         error, er_type, prod_id, mfg_id, serial} !== RST_VEC) begin
      fails++;
      $display("FAIL midreset outputs got %h exp %h", {bus_req, bus_read,
               bus_addr, bus_dout, CFGIN_n, busy, done, found, error,
               er_type, prod_id, mfg_id, serial}, RST_VEC);
    end
    @(negedge CLK);
    RESET_n = 1;
    base = log_q.size();
    model_full();
    build_exp(-1, 1, card_valid());
    run_scan(st);
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error}
        !== res_vec(card_valid(), 1, 0) || !log_ok(base)) begin
      fails++;
      $display("FAIL midreset rescan got %h exp %h", {er_type, prod_id,
               mfg_id, serial, found, done, error}, res_vec(card_valid(), 1, 0));
    end
  endtask

  task automatic test_spurious_and_busy();
    int base = log_q.size();
    bit v = card_valid();
    spur_req = ~spur_req;
    repeat (4) @(negedge CLK);
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error, bus_req,
         CFGIN_n, busy} !== {res_vec(v, 1, 0), 3'b010}
        || log_q.size() != base) begin
      fails++;
      $display("FAIL spurious idle got %h exp %h", {er_type, prod_id, mfg_id,
               serial, found, done, error, bus_req, CFGIN_n, busy},
               {res_vec(v, 1, 0), 3'b010});
    end
    new_card();
    model_full();
    v = card_valid();
    build_exp(-1, 1, v);
    @(negedge CLK);
    start = 1;
    @(negedge CLK);
    start = 0;
    for (int i = 0; i < 3000 && done !== 1'b1; i++) begin
      @(negedge CLK);
      start = (i == 10 || i == 30);
    end
    start = 0;
    repeat (40) @(negedge CLK);
    tests++;
    if (!log_ok(base)) begin
      fails++;
      $display("FAIL busy_start accesses got %0d exp %0d entries",
               log_q.size() - base, exp_q.size());
    end
    tests++;
    if ({er_type, prod_id, mfg_id, serial, found, done, error}
        !== res_vec(v, 1, 0)) begin
      fails++;
      $display("FAIL busy_start results got %h exp %h", {er_type, prod_id,
               mfg_id, serial, found, done, error}, res_vec(v, 1, 0));
    end
    tests++;
    if ({busy, bus_req, CFGIN_n} !== 3'b001) begin
      fails++;
      $display("FAIL busy_start idle got %b exp 001", {busy, bus_req, CFGIN_n});
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_absent();
    test_timeout();
    test_chain_timeout();
    test_mid_reset();
    test_spurious_and_busy();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
